// File: rtl/stopwatch_log.sv
// stopwatch_log: timestamped event log behind the stopwatch FSM.
// Each rising edge of `valid` stores {optiune, time_in} into a 2^ADDR_SIZE
// entry FIFO; entries are read back one per rd_req cycle with one cycle of
// latency. fsm_reset empties the log.
// Optional feature macro: LOG_OVERWRITE_EN -- when defined, a capture into a
// full log evicts the oldest entry; otherwise the new capture is dropped.
// In both modes the sticky overflow flag is set.
module stopwatch_log #(
    parameter int ADDR_SIZE = 4,
    parameter int TIME_W    = 14,
    parameter int TAG_W     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid,
    input  logic                      fsm_reset,
    input  logic [TAG_W-1:0]          optiune,
    input  logic [TIME_W-1:0]         time_in,
    input  logic                      rd_req,
    output logic [TAG_W+TIME_W-1:0]   rd_data,
    output logic                      rd_valid,
    output logic                      rd_err,
    output logic [ADDR_SIZE:0]        count,
    output logic                      empty,
    output logic                      full,
    output logic                      overflow
);

    localparam int DEPTH   = 1 << ADDR_SIZE;
    localparam int ENTRY_W = TAG_W + TIME_W;
    localparam logic [ADDR_SIZE:0] DEPTH_CNT = (ADDR_SIZE + 1)'(DEPTH);

    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic                 valid_q;

    logic capture;
    logic rd_accept;
    logic rd_reject;
    logic cap_store;
    logic cap_full;
    logic mem_we;
    logic evict;

    // Status flags decoded from the registered entry count
    always_comb begin
        empty = (count == '0);
        full  = (count == DEPTH_CNT);
    end

    // Decode this cycle's capture/read actions; fsm_reset suppresses both
    always_comb begin
        capture   = valid & ~valid_q;
        rd_accept = rd_req & ~empty & ~fsm_reset;
        rd_reject = rd_req &  empty & ~fsm_reset;
        // A read in the same cycle frees a slot, so a full log still accepts
        cap_store = capture & ~fsm_reset & (~full | rd_accept);
        cap_full  = capture & ~fsm_reset & full & ~rd_accept;
        mem_we    = cap_store;
        evict     = 1'b0;
`ifdef LOG_OVERWRITE_EN
        // Full log: overwrite the oldest slot (wr_ptr == rd_ptr when full)
        if (cap_full) begin
            mem_we = 1'b1;
            evict  = 1'b1;
        end
`endif
    end

    // Log storage: single write port, contents are not reset
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_ptr] <= {optiune, time_in};
        end
    end

    // Pointers, count, flags and the registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q  <= valid;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            if (fsm_reset) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (rd_accept) begin
                    rd_data  <= mem[rd_ptr];
                    rd_valid <= 1'b1;
                end
                if (rd_reject) begin
                    rd_err <= 1'b1;
                end
                if (rd_accept || evict) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (mem_we) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (cap_full) begin
                    overflow <= 1'b1;
                end
                case ({cap_store, rd_accept})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: doc/stopwatch_log.md
Name: stopwatch_log

Overview:
- Downstream consumer of the FSM stage: watches its `valid` and `fsm_reset` outputs together with the selected `optiune` and the cascaded-counter time digits.
- Each new `valid` event stores one timestamped entry into a small on-chip FIFO log.
- Entries are read back one per request for display/readout.
- `fsm_reset` clears the whole log.

Parameters:
- ADDR_SIZE, 4, log2 of log depth; DEPTH = 2^ADDR_SIZE = 16 entries.
- TIME_W, 14, width of packed time word {out1[3:0], out2[2:0], out3[3:0], out4[2:0]}.
- TAG_W, 3, width of option tag (matches `optiune`).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid  in  1  capture event from FSM; level, may stay high several cycles.
- fsm_reset  in  1  clear-log request from FSM; level-sensitive.
- optiune  in  TAG_W  option tag stored with entry.
- time_in  in  TIME_W  current counter digits, packed as above.
- rd_req  in  1  read request; one entry consumed per cycle high.
- rd_data  out  TAG_W+TIME_W  {tag, time} of entry read.
- rd_valid  out  1  one-cycle pulse: rd_data updated this cycle.
- rd_err  out  1  one-cycle pulse: rd_req rejected, log empty.
- count  out  ADDR_SIZE+1  number of stored entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a capture found the log full.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - rst high at a clock edge forces: wr_ptr=0, rd_ptr=0, count=0, overflow=0, rd_data=0, rd_valid=0, rd_err=0, valid_q=0, empty=1, full=0.
  - Memory contents are don't-care.
  - Reset mid-operation discards everything; a pending rd_req gets no response.
- Edge detect: valid_q <= valid every cycle. A capture is `valid & ~valid_q`, i.e. exactly one capture per high period of valid.
- Capture:
  - mem[wr_ptr] <= {optiune, time_in}, sampled in the cycle the capture is detected.
  - wr_ptr++ (wraps DEPTH-1 -> 0); count++.
  - Visible on count/empty/full on the next cycle.
- Read (`rd_req` high, count > 0 at the edge):
  - rd_data <= mem[rd_ptr]; rd_valid=1 for one cycle; rd_ptr++ (wraps); count--.
  - Latency: data and rd_valid appear the cycle after the rd_req cycle.
  - rd_data holds its value until the next accepted read.
- Read when empty: rd_err=1 for one cycle; rd_valid=0; rd_data, pointers and count unchanged.
- Capture + read in the same cycle:
  - count > 0: both performed; count unchanged; no overflow even if full.
  - count == 0: capture performed; read rejected with rd_err (no bypass); count becomes 1.
- Capture when full and no read: behaviour set by optional feature; overflow <= 1 in both modes.
- fsm_reset:
  - Clears wr_ptr, rd_ptr, count and overflow.
  - Overrides any capture or read in the same cycle; rd_valid and rd_err stay 0.
  - valid_q still updates, so a valid level held across fsm_reset does not recapture afterwards.
- Priority: rst > fsm_reset > read/capture.
- full and empty are decoded combinationally from the registered count.
- Memory: single write port, registered read; maps to the team's sram style.

Optional Feature:
- Macro: LOG_OVERWRITE_EN.
- Defined: capture into a full log (no read that cycle) overwrites the oldest entry.
  - mem[wr_ptr] written; wr_ptr++ and rd_ptr++; count stays DEPTH; overflow set.
- Undefined: the new capture is dropped.
  - Memory, pointers and count unchanged; overflow set.

Test Plan:
- Reset then idle → count=0, empty=1, full=0, overflow=0, rd_valid=0. Then rd_req 1 cycle → rd_err pulse, rd_data=0.
- Single capture: time_in=14'h1A5B, optiune=3'd5, valid high 4 cycles → exactly one entry, count=1. Then rd_req → next cycle rd_valid=1, rd_data={3'd5,14'h1A5B}, count=0, empty=1.
- 16 captures with time_in=0..15 and optiune=i[2:0] → full=1, count=16. A 17th capture (time_in=99):
  - Macro off: dropped, overflow=1; 16 reads return 0..15.
  - Macro on: overflow=1; reads return 1..15 then 99.
- Wrap-around: interleave 20 capture/read pairs → rd_data follows capture order through pointer wrap; count never exceeds 1.
- Capture and rd_req same cycle:
  - At count=3: count stays 3; rd_data = oldest entry.
  - At count=0: rd_err pulses; count=1; the following read returns the captured value.
- fsm_reset asserted for 1 cycle with count=5, overflow=1, plus coincident valid rise and rd_req → count=0, overflow=0, no rd_valid/rd_err. valid held high afterwards causes no capture.
